// File: rtl/i2s_transmitter.sv
// I2S transmitter: buffers mono samples in a small FIFO and serialises each
// sample onto both I2S channels, MSB first, with the standard one-bit delay
// relative to the word-select edge. The bit clock is derived from clk by a
// divider. Sticky flags report dropped writes and starved loads.
module i2s_transmitter #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int BCLK_HALF    = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [SAMPLE_WIDTH-1:0]         sample_in,
  input  logic                            sample_in_valid,
  output logic                            sample_req,
  input  logic                            clear_flags,
  output logic                            i2s_bclk,
  output logic                            i2s_lrclk,
  output logic                            i2s_sdata,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            overflow,
  output logic                            underflow
);

  localparam int LW = $clog2(FIFO_DEPTH);
  localparam int AW = (LW > 0) ? LW : 1;
  localparam int DW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

  localparam logic [DW-1:0] C_DIV_LAST = DW'(BCLK_HALF - 1);
  localparam logic [AW-1:0] C_PTR_LAST = AW'(FIFO_DEPTH - 1);
  localparam logic [LW:0]   C_FULL     = (LW + 1)'(FIFO_DEPTH);

  // Bit-clock generation and frame position
  logic [DW-1:0]            r_div;
  logic                     r_bclk;
  logic [4:0]               r_slot;

  // Registered outputs
  logic                     r_lrclk;
  logic                     r_sdata;
  logic                     r_req;
  logic                     r_ovf;
  logic                     r_unf;

  // Sample currently being shifted out
  logic [SAMPLE_WIDTH-1:0]  r_cur;

  // FIFO storage and bookkeeping
  logic [SAMPLE_WIDTH-1:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0]            r_rd_ptr;
  logic [AW-1:0]            r_wr_ptr;
  logic [LW:0]              r_count;

  // Combinational control
  logic                     w_div_wrap;
  logic                     w_fall;
  logic                     w_load;
  logic                     w_empty;
  logic                     w_full;
  logic                     w_pop;
  logic                     w_push;
  logic                     w_ovf_set;
  logic                     w_unf_set;
  logic [4:0]               w_next_slot;
  logic [SAMPLE_WIDTH-1:0]  w_next_cur;
  logic [15:0]              w_chan;
  logic [3:0]               w_pos;
  logic                     w_next_bit;
  logic                     w_next_lr;

  assign w_div_wrap  = (r_div == C_DIV_LAST);
  assign w_fall      = w_div_wrap & r_bclk;
  assign w_load      = w_fall & (r_slot == 5'd0);
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == C_FULL);
  assign w_pop       = w_load & ~w_empty;
  // A pop in the same cycle frees a slot, so a push to a full FIFO still lands.
  assign w_push      = sample_in_valid & (~w_full | w_pop);
  assign w_ovf_set   = sample_in_valid & w_full & ~w_pop;
  assign w_unf_set   = w_load & w_empty;
  assign w_next_slot = r_slot + 5'd1;

  // Word that will be held in cur after this cycle (zero on a starved load)
  always_comb begin
    w_next_cur = r_cur;
    if (w_load) begin
      w_next_cur = w_empty ? '0 : r_mem[r_rd_ptr];
    end
  end

  // Each I2S channel is 16 slots wide; the sample is left-justified into it,
  // truncating extra LSBs or padding missing ones with zeros.
  generate
    if (SAMPLE_WIDTH >= 16) begin : g_chan_trunc
      assign w_chan = w_next_cur[SAMPLE_WIDTH-1 -: 16];
    end else begin : g_chan_pad
      assign w_chan = {w_next_cur, {(16 - SAMPLE_WIDTH){1'b0}}};
    end
  endgenerate

  // Map the upcoming slot to a bit position within the channel word.
  // Slot 0 carries the LSB of the right channel (one-bit delay), so it
  // behaves as position 15 of the word still held in cur.
  always_comb begin
    w_pos = 4'd15;
    if (w_next_slot == 5'd0) begin
      w_pos = 4'd15;
    end else if (w_next_slot <= 5'd16) begin
      w_pos = 4'(w_next_slot - 5'd1);
    end else begin
      w_pos = 4'(w_next_slot - 5'd17);
    end
    w_next_bit = w_chan[4'd15 - w_pos];
    w_next_lr  = (w_next_slot >= 5'd16);
  end

  // Divider counter and bit clock; bclk toggles whenever the divider wraps
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_bclk <= 1'b0;
    end else begin
      if (w_div_wrap) begin
        r_div  <= '0;
        r_bclk <= ~r_bclk;
      end else begin
        r_div  <= r_div + 1'b1;
      end
    end
  end

  // Slot counter, word select, serial data and current word; all change on bclk falls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_slot  <= '0;
      r_lrclk <= 1'b0;
      r_sdata <= 1'b0;
      r_cur   <= '0;
    end else if (w_fall) begin
      r_slot  <= w_next_slot;
      r_lrclk <= w_next_lr;
      r_sdata <= w_next_bit;
      r_cur   <= w_next_cur;
    end
  end

  // One-cycle request pulse aligned with each load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req <= 1'b0;
    end else begin
      r_req <= w_load;
    end
  end

  // FIFO storage; contents need no reset since the pointers gate every read
  always_ff @(posedge clk) begin
    if (w_push && rst_n) begin
      r_mem[r_wr_ptr] <= sample_in;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == C_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      end
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == C_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags; a set in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (clear_flags) begin
        r_ovf <= 1'b0;
      end
      if (w_unf_set) begin
        r_unf <= 1'b1;
      end else if (clear_flags) begin
        r_unf <= 1'b0;
      end
    end
  end

  assign sample_req = r_req;
  assign i2s_bclk   = r_bclk;
  assign i2s_lrclk  = r_lrclk;
  assign i2s_sdata  = r_sdata;
  assign fifo_level = r_count;
  assign overflow   = r_ovf;
  assign underflow  = r_unf;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed testbench for i2s_transmitter with BCLK_HALF=2, FIFO_DEPTH=4.
// One bclk period is 4 clk cycles; one frame (32 slots) is 128 cycles.
module tb_i2s_transmitter;

  logic        clk;
  logic        rst_n;
  logic [15:0] sample_in;
  logic        sample_in_valid;
  logic        sample_req;
  logic        clear_flags;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        underflow;

  int errors;
  int checks;

  i2s_transmitter #(
    .SAMPLE_WIDTH(16),
    .BCLK_HALF(2),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sample_in(sample_in),
    .sample_in_valid(sample_in_valid),
    .sample_req(sample_req),
    .clear_flags(clear_flags),
    .i2s_bclk(i2s_bclk),
    .i2s_lrclk(i2s_lrclk),
    .i2s_sdata(i2s_sdata),
    .fifo_level(fifo_level),
    .overflow(overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and settle just after it
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold reset for a few edges, then release; the next edge is cycle 1
  task automatic do_reset();
    rst_n = 1'b0;
    sample_in_valid = 1'b0;
    clear_flags = 1'b0;
    sample_in = '0;
    tick(3);
    rst_n = 1'b1;
  endtask

  // Positioned just after a load edge: record slot 1..31 and slot 0 bits,
  // ending positioned just after the next load edge.
  task automatic capture_frame(output logic [31:0] bits, output logic [31:0] lr);
    for (int i = 0; i < 32; i++) begin
      if (i > 0) tick(4);
      bits[31-i] = i2s_sdata;
      lr[31-i]   = i2s_lrclk;
    end
    tick(4);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_flags = 1'b0;
    sample_in = 16'h1234;
    sample_in_valid = 1'b1;
    tick(3);
    checks++; if (i2s_bclk !== 1'b0) begin errors++; $display("FAIL reset_bclk: got %b expected 0", i2s_bclk); end
    checks++; if (i2s_lrclk !== 1'b0) begin errors++; $display("FAIL reset_lrclk: got %b expected 0", i2s_lrclk); end
    checks++; if (i2s_sdata !== 1'b0) begin errors++; $display("FAIL reset_sdata: got %b expected 0", i2s_sdata); end
    checks++; if (sample_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", sample_req); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {overflow, underflow}); end
    sample_in_valid = 1'b0;
  endtask

  task automatic test_idle();
    do_reset();
    tick(1);
    checks++; if (i2s_bclk !== 1'b0) begin errors++; $display("FAIL idle_bclk_c1: got %b expected 0", i2s_bclk); end
    tick(1);
    checks++; if (i2s_bclk !== 1'b1) begin errors++; $display("FAIL idle_bclk_c2: got %b expected 1", i2s_bclk); end
    tick(1);
    checks++; if (sample_req !== 1'b0) begin errors++; $display("FAIL idle_req_c3: got %b expected 0", sample_req); end
    tick(1);
    checks++; if (sample_req !== 1'b1) begin errors++; $display("FAIL idle_req_c4: got %b expected 1", sample_req); end
    checks++; if (i2s_bclk !== 1'b0) begin errors++; $display("FAIL idle_bclk_c4: got %b expected 0", i2s_bclk); end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL idle_underflow: got %b expected 1", underflow); end
    for (int c = 5; c < 132; c++) begin
      tick(1);
      checks++; if (sample_req !== 1'b0) begin errors++; $display("FAIL idle_req_gap c%0d: got %b expected 0", c, sample_req); end
      checks++; if (i2s_sdata !== 1'b0) begin errors++; $display("FAIL idle_sdata c%0d: got %b expected 0", c, i2s_sdata); end
    end
    tick(1);
    checks++; if (sample_req !== 1'b1) begin errors++; $display("FAIL idle_req_c132: got %b expected 1", sample_req); end
  endtask

  task automatic test_single_word();
    logic [31:0] bits;
    logic [31:0] lr;
    do_reset();
    sample_in = 16'hA5C3;
    sample_in_valid = 1'b1;
    tick(1);
    sample_in_valid = 1'b0;
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL single_level_write: got %0d expected 1", fifo_level); end
    tick(3);
    checks++; if (sample_req !== 1'b1) begin errors++; $display("FAIL single_req: got %b expected 1", sample_req); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL single_level_pop: got %0d expected 0", fifo_level); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL single_no_underflow: got %b expected 0", underflow); end
    capture_frame(bits, lr);
    checks++; if (bits !== 32'hA5C3_A5C3) begin errors++; $display("FAIL single_bits: got %h expected a5c3a5c3", bits); end
    checks++; if (lr !== 32'h0001_FFFE) begin errors++; $display("FAIL single_lrclk: got %h expected 0001fffe", lr); end
    checks++; if (sample_req !== 1'b1) begin errors++; $display("FAIL single_req_next: got %b expected 1", sample_req); end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL single_underflow_next: got %b expected 1", underflow); end
  endtask

  task automatic test_overflow();
    logic [31:0] bits;
    logic [31:0] lr;
    logic [15:0] exp_words [6];
    logic [15:0] wr_vals [5];
    exp_words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h6666, 16'h0000};
    wr_vals   = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    do_reset();
    tick(4);
    checks++; if (sample_req !== 1'b1) begin errors++; $display("FAIL ovf_first_req: got %b expected 1", sample_req); end
    for (int i = 0; i < 5; i++) begin
      sample_in = wr_vals[i];
      sample_in_valid = 1'b1;
      tick(1);
    end
    sample_in_valid = 1'b0;
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level_full: got %0d expected 4", fifo_level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag_set: got %b expected 1", overflow); end
    sample_in = 16'h7777;
    sample_in_valid = 1'b1;
    clear_flags = 1'b1;
    tick(1);
    sample_in_valid = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_beats_clear: got %b expected 1", overflow); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL unf_cleared: got %b expected 0", underflow); end
    tick(1);
    clear_flags = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_cleared: got %b expected 0", overflow); end
    tick(120);
    sample_in = 16'h6666;
    sample_in_valid = 1'b1;
    tick(1);
    sample_in_valid = 1'b0;
    checks++; if (sample_req !== 1'b1) begin errors++; $display("FAIL ovf_load_req: got %b expected 1", sample_req); end
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL pushpop_level: got %0d expected 4", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pushpop_no_ovf: got %b expected 0", overflow); end
    for (int f = 0; f < 6; f++) begin
      capture_frame(bits, lr);
      checks++; if (bits !== {exp_words[f], exp_words[f]}) begin errors++; $display("FAIL ovf_frame%0d: got %h expected %h", f, bits, {exp_words[f], exp_words[f]}); end
      checks++; if (fifo_level !== ((f < 3) ? 3'(3 - f) : 3'd0)) begin errors++; $display("FAIL ovf_level_f%0d: got %0d expected %0d", f, fifo_level, (f < 3) ? 3 - f : 0); end
      checks++; if (underflow !== (f >= 4)) begin errors++; $display("FAIL ovf_unf_f%0d: got %b expected %b", f, underflow, (f >= 4)); end
    end
  endtask

  task automatic test_order();
    logic [31:0] bits;
    logic [31:0] lr;
    do_reset();
    sample_in = 16'h8000;
    sample_in_valid = 1'b1;
    tick(1);
    sample_in = 16'h7FFF;
    tick(1);
    sample_in_valid = 1'b0;
    tick(1);
    checks++; if (i2s_sdata !== 1'b0) begin errors++; $display("FAIL order_pre_slot0: got %b expected 0", i2s_sdata); end
    tick(1);
    checks++; if (i2s_sdata !== 1'b1) begin errors++; $display("FAIL order_msb_8000: got %b expected 1", i2s_sdata); end
    capture_frame(bits, lr);
    checks++; if (bits !== 32'h8000_8000) begin errors++; $display("FAIL order_frame0: got %h expected 80008000", bits); end
    checks++; if (i2s_sdata !== 1'b0) begin errors++; $display("FAIL order_msb_7fff: got %b expected 0", i2s_sdata); end
    capture_frame(bits, lr);
    checks++; if (bits !== 32'h7FFF_7FFF) begin errors++; $display("FAIL order_frame1: got %h expected 7fff7fff", bits); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    sample_in = 16'hAAAA; sample_in_valid = 1'b1; tick(1);
    sample_in = 16'hBBBB; tick(1);
    sample_in = 16'hCCCC; tick(1);
    sample_in_valid = 1'b0;
    tick(1);
    checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL mid_level_queued: got %0d expected 2", fifo_level); end
    tick(76);
    checks++; if (i2s_lrclk !== 1'b1) begin errors++; $display("FAIL mid_slot20_lrclk: got %b expected 1", i2s_lrclk); end
    rst_n = 1'b0;
    sample_in = 16'hDDDD;
    sample_in_valid = 1'b1;
    tick(1);
    sample_in_valid = 1'b0;
    checks++; if ({i2s_bclk, i2s_lrclk, i2s_sdata, sample_req} !== 4'b0000) begin errors++; $display("FAIL mid_outputs: got %b expected 0000", {i2s_bclk, i2s_lrclk, i2s_sdata, sample_req}); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL mid_level: got %0d expected 0", fifo_level); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL mid_flags: got %b expected 00", {overflow, underflow}); end
    clear_flags = 1'b1;
    tick(1);
    clear_flags = 1'b0;
    rst_n = 1'b1;
    tick(3);
    checks++; if (sample_req !== 1'b0) begin errors++; $display("FAIL mid_req_early: got %b expected 0", sample_req); end
    tick(1);
    checks++; if (sample_req !== 1'b1) begin errors++; $display("FAIL mid_req_c4: got %b expected 1", sample_req); end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL mid_fifo_discarded: got %b expected 1", underflow); end
    checks++; if (i2s_sdata !== 1'b0) begin errors++; $display("FAIL mid_sdata: got %b expected 0", i2s_sdata); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    sample_in = '0;
    sample_in_valid = 1'b0;
    clear_flags = 1'b0;
    test_reset();
    test_idle();
    test_single_word();
    test_overflow();
    test_order();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
